// File: rtl/mac_frame_scheduler.sv
// mac_frame_scheduler: round-robin owner of the MAC frame generator; grants one of i_req, drives o_grant/o_gen_start/o_gen_length for the frame's beat count, pulses o_ack or o_aborted, then holds the inter-packet gap (o_busy, o_frames_sent)
module mac_frame_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int IPG_CYCLES  = 2,
    parameter int MIN_PAYLOAD = 46,
    parameter int MAX_PAYLOAD = 1500
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic [NUM_REQ-1:0]    i_req,
    input  logic [NUM_REQ*16-1:0] i_len,
    input  logic                  i_abort,
    output logic [NUM_REQ-1:0]    o_grant,
    output logic                  o_gen_start,
    output logic [15:0]           o_gen_length,
    output logic [NUM_REQ-1:0]    o_ack,
    output logic                  o_aborted,
    output logic                  o_busy,
    output logic [31:0]           o_frames_sent
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [1:0] IDLE = 2'd0, TX = 2'd1, IFG = 2'd2;
    localparam logic [1:0] DONE_STATE = (IPG_CYCLES == 0) ? IDLE : IFG;
    localparam logic [15:0] GAP_LOAD = 16'((IPG_CYCLES == 0) ? 0 : IPG_CYCLES - 1);
    logic [1:0] state_q, state_d;
    logic [15:0] cnt_q, cnt_d, len_q, len_d;
    logic [IW-1:0] last_q, last_d, win, idx;
    logic [NUM_REQ-1:0] grant_q, grant_d, ack_q, ack_d;
    logic start_q, start_d, aborted_q, aborted_d, busy_q, busy_d, found;
    logic [31:0] frames_q, frames_d;
    logic [15:0] raw_len, pay_len, beats;

    always_comb begin
        win = '0;
        idx = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IW'((int'(last_q) + i) % NUM_REQ);
            if (!found && i_req[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
        raw_len = i_len[{win, 4'b0} +: 16];
        pay_len = raw_len < 16'(MIN_PAYLOAD) ? 16'(MIN_PAYLOAD) :
                  raw_len > 16'(MAX_PAYLOAD) ? 16'(MAX_PAYLOAD) : raw_len;
        beats = (pay_len + 16'd33) >> 3;
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        last_d = last_q;
        grant_d = grant_q;
        start_d = start_q;
        len_d = len_q;
        frames_d = frames_q;
        ack_d = '0;
        aborted_d = 1'b0;
        if (state_q == IDLE) begin
            if (i_enable && found) begin
                state_d = TX;
                cnt_d = beats - 16'd1;
                last_d = win;
                grant_d = NUM_REQ'(1) << win;
                start_d = 1'b1;
                len_d = pay_len;
            end
        end else if (state_q == TX) begin
            if (i_abort || cnt_q == 16'd0) begin
                state_d = DONE_STATE;
                cnt_d = GAP_LOAD;
                grant_d = '0;
                start_d = 1'b0;
                ack_d = i_abort ? '0 : grant_q;
                aborted_d = i_abort;
                frames_d = frames_q + {31'd0, !i_abort};
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end else begin
            state_d = (cnt_q == 16'd0) ? IDLE : state_q;
            cnt_d = (cnt_q == 16'd0) ? cnt_q : cnt_q - 16'd1;
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            last_q <= IW'(NUM_REQ - 1);
            grant_q <= '0;
            start_q <= 1'b0;
            len_q <= '0;
            frames_q <= '0;
            ack_q <= '0;
            aborted_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            last_q <= last_d;
            grant_q <= grant_d;
            start_q <= start_d;
            len_q <= len_d;
            frames_q <= frames_d;
            ack_q <= ack_d;
            aborted_q <= aborted_d;
            busy_q <= busy_d;
        end
    end

    assign o_grant = grant_q;
    assign o_gen_start = start_q;
    assign o_gen_length = len_q;
    assign o_ack = ack_q;
    assign o_aborted = aborted_q;
    assign o_busy = busy_q;
    assign o_frames_sent = frames_q;
endmodule
